// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit -- load-use hazard detection and operand forwarding select.
//
// Tracks the instructions occupying EX, MEM and WB. For each EX source
// operand it picks the youngest in-flight producer. When a consumer in ID
// depends on a load that is still in EX, it raises a one-cycle stall.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   id_valid     an instruction is present in ID
//   id_rs        ID source indices; source i is at [i*ADDR_W +: ADDR_W]
//   id_rd        ID destination index
//   id_regwrite  the ID instruction writes id_rd
//   id_memread   the ID instruction is a load (LDUR)
//   flush        branch flush; kills the ID and EX occupants
//   stall        hold PC and IF/ID, and insert a bubble into EX
//   fwd_sel      2 bits per source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_count  saturating count of load-use stall cycles
//
// Build option: define FWD_HAZARD_STALL_CNT_EN to get the stall counter.
// Without it, stall_count is tied to 0 and no counter flops exist.

module fwd_src_sel #(
    parameter int ADDR_W = 5
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] rs,
    input  logic              mem_ok,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              wb_ok,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic [1:0]        sel
);
    always_comb begin
        sel = 2'b00;
        // MEM is the younger producer, so it is checked first.
        if (en && mem_ok && mem_rd == rs)
            sel = 2'b10;
        else if (en && wb_ok && wb_rd == rs)
            sel = 2'b01;
    end
endmodule

module fwd_hazard_unit #(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int ZERO_REG = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic [15:0]               stall_count
);
    localparam int STAGES = 2;
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic              regwrite;
        logic              memread;
    } ent_t;

    // Valid bits by stage: [0] EX, [1] MEM, [2] WB.
    logic [STAGES:0]                  vld_pipe;
    ent_t                             ex_q, mem_q, wb_q;
    logic [NUM_SRC-1:0][ADDR_W-1:0]   ex_rs_q;
    logic [NUM_SRC-1:0][ADDR_W-1:0]   id_rs_a;
    logic [NUM_SRC-1:0][1:0]          sel_a;
    logic                             rs_hit;
    logic                             load_ex;

    assign id_rs_a = id_rs;

    always_comb begin
        rs_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (id_rs_a[i] == ex_q.rd) rs_hit = 1'b1;
    end

    // Only a load in EX needs a stall. Other producers are forwarded from
    // MEM on the next cycle. Flush wins, and reset masks the stall.
    assign stall = !reset && id_valid && !flush && vld_pipe[0] &&
                   ex_q.memread && ex_q.regwrite && (ex_q.rd != ZR) && rs_hit;

    assign load_ex = id_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            ex_rs_q  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], load_ex};
            mem_q    <= ex_q;
            wb_q     <= mem_q;
            if (load_ex) begin
                ex_q    <= '{rd: id_rd, regwrite: id_regwrite, memread: id_memread};
                ex_rs_q <= id_rs_a;
            end
        end
    end

    // Load data is not available until WB, so a load in MEM never forwards.
    logic mem_ok, wb_ok, ex_en;
    assign ex_en  = vld_pipe[0] && !reset;
    assign mem_ok = vld_pipe[1] && mem_q.regwrite && !mem_q.memread && (mem_q.rd != ZR);
    assign wb_ok  = vld_pipe[2] && wb_q.regwrite && (wb_q.rd != ZR);

    // The WB memread bit is tracked for completeness but has no consumer.
    logic unused_wb_memread;
    assign unused_wb_memread = wb_q.memread;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_sel #(.ADDR_W(ADDR_W)) u_sel (
            .en     (ex_en),
            .rs     (ex_rs_q[g]),
            .mem_ok (mem_ok),
            .mem_rd (mem_q.rd),
            .wb_ok  (wb_ok),
            .wb_rd  (wb_q.rd),
            .sel    (sel_a[g])
        );
    end

    assign fwd_sel = sel_a;

`ifdef FWD_HAZARD_STALL_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (stall && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end
    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit, built with NUM_SRC=3.
module tb_fwd_hazard_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [14:0] id_rs;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        flush;
    logic        stall;
    logic [5:0]  fwd_sel;
    logic [15:0] stall_count;

    int n_chk = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.ADDR_W(5), .NUM_SRC(3), .ZERO_REG(31)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .stall_count (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
        id_valid    = v;
        id_rs       = {r2, r1, r0};
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
        #1;
    endtask

    task automatic nop();
        drv(1'b0, 5'd31, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    task automatic chk_cnt(input string tag);
`ifdef FWD_HAZARD_STALL_CNT_EN
        chk(tag, {16'd0, stall_count}, exp_cnt);
`else
        chk(tag, {16'd0, stall_count}, 32'd0);
`endif
    endtask

    // A load followed directly by a dependent ADD costs exactly one stall cycle.
    task automatic ld_use(input logic [4:0] r);
        drv(1'b1, 5'd8, 5'd9, 5'd31, r, 1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b1, r, 5'd9, 5'd31, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("ldu_stall_on", {31'd0, stall}, 32'd1);
        tick();
        exp_cnt++;
        chk("ldu_stall_off", {31'd0, stall}, 32'd0);
        tick();
        drain();
    endtask

    initial begin
        reset = 1'b1;
        drv(1'b1, 5'd1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_fwd", {26'd0, fwd_sel}, 32'd0);
        chk_cnt("rst_cnt");
        reset = 1'b0;
        nop();
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_fwd", {26'd0, fwd_sel}, 32'd0);
        tick();

        // ADD X1 then ADD rs0=X1: forward from EX/MEM, no stall
        drv(1'b1, 5'd2, 5'd3, 5'd31, 5'd1, 1'b1, 1'b0, 1'b0);
        chk("alu_p_stall", {31'd0, stall}, 32'd0);
        tick();
        drv(1'b1, 5'd1, 5'd7, 5'd31, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("alu_c_stall", {31'd0, stall}, 32'd0);
        tick();
        nop();
        chk("alu_fwd_mem", {26'd0, fwd_sel}, 32'b000010);
        tick();
        drain();

        // LDUR X2 then ADD rs0=X2: one stall, then forward from MEM/WB
        drv(1'b1, 5'd8, 5'd9, 5'd31, 5'd2, 1'b1, 1'b1, 1'b0);
        chk("ld_p_stall", {31'd0, stall}, 32'd0);
        tick();
        drv(1'b1, 5'd2, 5'd11, 5'd31, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("ld_stall_1", {31'd0, stall}, 32'd1);
        tick();
        exp_cnt++;
        chk("ld_stall_2", {31'd0, stall}, 32'd0);
        chk("ld_bubble_fwd", {26'd0, fwd_sel}, 32'd0);
        tick();
        nop();
        chk("ld_fwd_wb", {26'd0, fwd_sel}, 32'b000001);
        tick();
        drain();

        // ADD X3, ADD X3, SUB X3,X3: MEM wins on both sources
        drv(1'b1, 5'd8, 5'd9, 5'd31, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drv(1'b1, 5'd12, 5'd13, 5'd31, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drv(1'b1, 5'd3, 5'd3, 5'd30, 5'd14, 1'b1, 1'b0, 1'b0);
        chk("dual_stall", {31'd0, stall}, 32'd0);
        tick();
        nop();
        chk("dual_fwd_prio", {26'd0, fwd_sel}, 32'b001010);
        tick();
        drain();

        // LDUR X31 then ADD rs0=X31: the zero register is never a hazard
        drv(1'b1, 5'd8, 5'd9, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b1, 5'd31, 5'd9, 5'd31, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("zr_stall", {31'd0, stall}, 32'd0);
        tick();
        nop();
        chk("zr_fwd", {26'd0, fwd_sel}, 32'd0);
        tick();
        drain();

        // ADD X31 two ahead of consumer of X31: no WB forward of zero reg
        drv(1'b1, 5'd8, 5'd9, 5'd30, 5'd31, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        drv(1'b1, 5'd31, 5'd9, 5'd30, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        chk("zr_wb_fwd", {26'd0, fwd_sel}, 32'd0);
        tick();
        drain();

        // LDUR X4, then a dependent load X20 arriving with flush: flush wins.
        // X20 must not reach EX, so a consumer of X20 does not stall.
        drv(1'b1, 5'd8, 5'd9, 5'd31, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b1, 5'd4, 5'd9, 5'd31, 5'd20, 1'b1, 1'b1, 1'b1);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        drv(1'b1, 5'd20, 5'd9, 5'd31, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("flush_bubble", {31'd0, stall}, 32'd0);
        tick();
        drain();

        // 3 sources: producer X5 two ahead, consumer rs1=X5
        drv(1'b1, 5'd8, 5'd9, 5'd31, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drv(1'b1, 5'd8, 5'd9, 5'd31, 5'd15, 1'b1, 1'b0, 1'b0);
        tick();
        drv(1'b1, 5'd16, 5'd5, 5'd17, 5'd18, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        chk("src1_fwd_wb", {26'd0, fwd_sel}, 32'b000100);
        tick();
        drain();

        ld_use(5'd6);
        ld_use(5'd7);
        chk_cnt("cnt_before_rst");

        // Reset arriving in the stall cycle aborts the stall
        drv(1'b1, 5'd8, 5'd9, 5'd31, 5'd21, 1'b1, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        drv(1'b1, 5'd21, 5'd9, 5'd31, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("rst_abort_stall", {31'd0, stall}, 32'd0);
        tick();
        exp_cnt = 0;
        chk_cnt("cnt_after_rst");
        chk("rst_fwd_2", {26'd0, fwd_sel}, 32'd0);
        reset = 1'b0;
        nop();
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands per instruction (range 1..4).
REQ-003 SHALL have parameter ZERO_REG, default 31, hardwired-zero index, never forwarded nor a stall cause.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port id_valid  input  1  ID-stage instruction present.
REQ-007 SHALL have port id_rs  input  NUM_SRC*ADDR_W  ID source indices, source i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port id_rd  input  ADDR_W  ID destination index.
REQ-009 SHALL have port id_regwrite  input  1  ID instruction writes id_rd.
REQ-010 SHALL have port id_memread  input  1  ID instruction is LDUR.
REQ-011 SHALL have port flush  input  1  branch flush, kills ID and EX occupants.
REQ-012 SHALL have port stall  output  1  hold PC and IF/ID, bubble into EX.
REQ-013 SHALL have port fwd_sel  output  NUM_SRC*2  per-source EX operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-014 SHALL have port stall_count  output  16  load-use stall cycle count.

Function
REQ-015 SHALL hold three tracking entries EX, MEM, WB, each {valid, rd, regwrite, memread}; EX additionally holds rs[NUM_SRC].
REQ-016 Each cycle SHALL advance MEM->WB and EX->MEM unconditionally.
REQ-017 ID->EX SHALL load ID fields when !stall && !flush && id_valid; otherwise EX SHALL become a bubble (valid=0).
REQ-018 stall SHALL be combinational: id_valid && !flush && EX.valid && EX.memread && EX.regwrite && EX.rd!=ZERO_REG && any id_rs[i]==EX.rd.
REQ-019 A load-use stall SHALL last exactly one cycle; the following cycle the load sits in MEM, stall deasserts, and the consumer's next EX cycle forwards 01 from WB.
REQ-020 fwd_sel[i] SHALL be 10 when MEM.valid && MEM.regwrite && !MEM.memread && MEM.rd!=ZERO_REG && MEM.rd==EX.rs[i].
REQ-021 Otherwise fwd_sel[i] SHALL be 01 when WB.valid && WB.regwrite && WB.rd!=ZERO_REG && WB.rd==EX.rs[i].
REQ-022 Otherwise fwd_sel[i] SHALL be 00; fwd_sel SHALL be 00 for all i when EX.valid=0.
REQ-023 MEM priority over WB SHALL hold per source independently (youngest producer wins).
REQ-024 flush SHALL take priority over stall in the same cycle: stall=0, EX becomes bubble, MEM/WB still advance.
REQ-025 Sources matching an EX entry that is not a load SHALL NOT stall (resolved by forwarding next cycle).

Reset
REQ-026 On reset, EX, MEM, WB valid bits SHALL clear to 0 and all stored fields to 0 in the same edge.
REQ-027 While reset is high, and the cycle after release, stall SHALL be 0 and fwd_sel SHALL be all 00.
REQ-028 stall_count SHALL reset to 0; reset asserted mid-stall SHALL abort the stall with no count increment on that edge.

Configuration
REQ-029 With macro FWD_HAZARD_STALL_CNT_EN defined, stall_count SHALL increment by 1 on each clock edge where stall=1 and reset=0, saturating at 16'hFFFF.
REQ-030 Without FWD_HAZARD_STALL_CNT_EN, stall_count SHALL be constant 0 and no counter flops SHALL be instantiated.

Verification
REQ-031 ADD X1 then ADD rs=X1 next cycle -> consumer's EX cycle fwd_sel[0]=10, stall never 1.
REQ-032 LDUR X2 then ADD rs1=X2 -> stall=1 for exactly one cycle, consumer's EX cycle fwd_sel[0]=01.
REQ-033 ADD X3, ADD X3, then SUB rs1=X3,rs2=X3 -> fwd_sel=10/10 (MEM wins over WB on both sources).
REQ-034 LDUR X31 then ADD rs1=X31 -> stall=0, fwd_sel=00; LDUR X4 with flush=1 in stall cycle -> stall=0, EX bubble.
REQ-035 NUM_SRC=3, producer X5 two ahead, rs2=X5 -> fwd_sel={00,01,00} (src2..src0); other sources 00.
REQ-036 With FWD_HAZARD_STALL_CNT_EN, 3 load-use pairs then reset -> stall_count=3 before, 0 after; without macro stall_count=0 throughout.
